// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and default parameters for the multi-channel PWM.
//   pwm_mode_t : counting mode (edge-aligned sawtooth or center-aligned triangle)
//   PWM_*_DEFAULT : default counter width, channel count and dead time
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    localparam int unsigned PWM_W_DEFAULT    = 11;
    localparam int unsigned PWM_N_DEFAULT    = 2;
    localparam int unsigned PWM_DEAD_DEFAULT = 8;

endpackage

// File: rtl/pwm_deadband.sv
// pwm_deadband: per-channel dead-time insertion with registered gate outputs.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear (run enable low); zeroes counter and outputs
//   raw   : registered compare result for this channel
//   hi    : high-side gate drive (registered)
//   lo    : low-side gate drive (registered)
// Every raw edge loads DEAD into the dead counter; both outputs stay low
// while the counter is nonzero, so hi and lo can never overlap.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int unsigned DEAD = PWM_DEAD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic raw,
    output logic hi,
    output logic lo
);

    localparam int unsigned   CW      = (DEAD > 0) ? $clog2(DEAD + 1) : 1;
    localparam logic [CW-1:0] DEAD_LD = CW'(DEAD);

    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          raw_prev_q, raw_prev_d;
    logic          hi_q, hi_d;
    logic          lo_q, lo_d;

    always_comb begin
        dcnt_d     = dcnt_q;
        raw_prev_d = raw;
        hi_d       = 1'b0;
        lo_d       = 1'b0;
        if (clr) begin
            dcnt_d     = '0;
            raw_prev_d = 1'b0;
        end else begin
            // A raw edge (re)starts the dead interval, even mid-count.
            if (raw != raw_prev_q) begin
                dcnt_d = DEAD_LD;
            end else if (dcnt_q != '0) begin
                dcnt_d = dcnt_q - CW'(1);
            end else begin
                dcnt_d = '0;
            end
            // Outputs follow raw only once the next counter value is zero,
            // which gives exactly DEAD low cycles after each edge.
            hi_d = (dcnt_d == '0) &  raw;
            lo_d = (dcnt_d == '0) & ~raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q     <= '0;
            raw_prev_q <= 1'b0;
            hi_q       <= 1'b0;
            lo_q       <= 1'b0;
        end else begin
            dcnt_q     <= dcnt_d;
            raw_prev_q <= raw_prev_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: N-channel PWM with one shared period counter, edge- or
// center-aligned counting, double-buffered duty and per-channel dead time.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   en           : run enable; low holds counter at 0 and forces outputs low
//   mode         : 0 = edge-aligned, 1 = center-aligned (taken at period start)
//   duty         : channel k duty in bits [k*W +: W] (taken at period start)
//   pwm_hi       : high-side gate drive per channel
//   pwm_lo       : low-side gate drive per channel
//   period_start : one-cycle pulse, registered, aligned with the raw compare
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int unsigned W    = PWM_W_DEFAULT,
    parameter int unsigned N    = PWM_N_DEFAULT,
    parameter int unsigned DEAD = PWM_DEAD_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           mode,
    input  logic [N*W-1:0] duty,
    output logic [N-1:0]   pwm_hi,
    output logic [N-1:0]   pwm_lo,
    output logic           period_start
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0]        cnt_q, cnt_d;
    logic                dir_down_q, dir_down_d;
    pwm_mode_t           mode_act_q, mode_act_d;
    logic [N-1:0][W-1:0] duty_act_q, duty_act_d;
    logic [N-1:0]        raw_q, raw_d;
    logic                ps_q, ps_d;

    logic                ps_now;
    logic                going_up;
    pwm_mode_t           mode_eff;
    logic [N-1:0][W-1:0] duty_eff;
    logic                clr;

    assign ps_now   = en && (cnt_q == '0);
    // The shadow registers load in the period-start cycle, so the compare and
    // the counter step in that same cycle already use the incoming values.
    assign mode_eff = ps_now ? pwm_mode_t'(mode) : mode_act_q;
    // A new period always begins counting up.
    assign going_up = ps_now | ~dir_down_q;
    assign clr      = ~en;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            duty_eff[k] = ps_now ? duty[k*W +: W] : duty_act_q[k];
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        dir_down_d = dir_down_q;
        mode_act_d = mode_act_q;
        duty_act_d = duty_act_q;
        raw_d      = '0;
        ps_d       = ps_now;

        if (ps_now) begin
            mode_act_d = pwm_mode_t'(mode);
            duty_act_d = duty_eff;
        end

        if (!en) begin
            cnt_d      = '0;
            dir_down_d = 1'b0;
        end else if (mode_eff == PWM_EDGE) begin
            cnt_d      = cnt_q + CNT_ONE;
            dir_down_d = 1'b0;
        end else if (going_up) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d      = CNT_MAX - CNT_ONE;
                dir_down_d = 1'b1;
            end else begin
                cnt_d      = cnt_q + CNT_ONE;
                dir_down_d = 1'b0;
            end
        end else begin
            if (cnt_q == CNT_ONE) begin
                cnt_d      = '0;
                dir_down_d = 1'b0;
            end else begin
                cnt_d      = cnt_q - CNT_ONE;
                dir_down_d = 1'b1;
            end
        end

        // Strict less-than: cnt never exceeds MAX, so raw always has at least
        // one low cycle per period for bootstrap refresh.
        for (int k = 0; k < N; k++) begin
            raw_d[k] = en && (cnt_q < duty_eff[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
            mode_act_q <= PWM_EDGE;
            duty_act_q <= '0;
            raw_q      <= '0;
            ps_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dir_down_q <= dir_down_d;
            mode_act_q <= mode_act_d;
            duty_act_q <= duty_act_d;
            raw_q      <= raw_d;
            ps_q       <= ps_d;
        end
    end

    assign period_start = ps_q;

    for (genvar g = 0; g < N; g++) begin : g_ch
        pwm_deadband #(
            .DEAD (DEAD)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .raw   (raw_q[g]),
            .hi    (pwm_hi[g]),
            .lo    (pwm_lo[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
module tb_pwm_multi_ch;

    localparam int W = 4;
    localparam int N = 2;

    // ---------------- clock / reset / DUTs ----------------
    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           en    = 1'b0;
    logic           mode  = 1'b0;
    logic [N*W-1:0] duty  = '0;
    logic [N-1:0]   hi_a, lo_a, hi_b, lo_b;
    logic           ps_a, ps_b;

    always #5 clk = ~clk;

    // dut: DEAD=2, dut_nd: DEAD=0 (raw visible directly on hi/lo)
    pwm_multi_ch #(.W(W), .N(N), .DEAD(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .duty         (duty),
        .pwm_hi       (hi_a),
        .pwm_lo       (lo_a),
        .period_start (ps_a)
    );

    pwm_multi_ch #(.W(W), .N(N), .DEAD(0)) dut_nd (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .duty         (duty),
        .pwm_hi       (hi_b),
        .pwm_lo       (lo_b),
        .period_start (ps_b)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- records ----------------
    typedef struct {
        logic         md;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        int           per;
        int           hi0;
        int           lo0;
        int           hi1;
        int           lo1;
        int           nhi0;
        int           nhi1;
    } vec_t;

    typedef struct {
        int per;
        int hi0;
        int lo0;
        int hi1;
        int lo1;
        int nhi0;
        int nlo0;
        int nhi1;
        int nlo1;
    } meas_t;

    vec_t tbl[7];
    vec_t exp_q[$];

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic md, input logic [W-1:0] d0, input logic [W-1:0] d1);
        mode         = md;
        duty[W-1:0]  = d0;
        duty[2*W-1:W] = d1;
    endtask

    task automatic wait_ps(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps_a !== 1'b1 && n < 200);
        if (ps_a !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: no period_start within 200 cycles", name);
        end
    endtask

    // Counts output-high cycles from the current period_start pulse up to the
    // next one. act_kind 1 writes duty0=10, 2 sets mode=center at act_idx.
    task automatic measure(input int act_idx, input int act_kind, output meas_t m);
        m = '{default: 0};
        do begin
            if (m.per == act_idx) begin
                if (act_kind == 1) duty[W-1:0] = W'(10);
                else if (act_kind == 2) mode = 1'b1;
            end
            m.hi0  += int'(hi_a[0]);
            m.lo0  += int'(lo_a[0]);
            m.hi1  += int'(hi_a[1]);
            m.lo1  += int'(lo_a[1]);
            m.nhi0 += int'(hi_b[0]);
            m.nlo0 += int'(lo_b[0]);
            m.nhi1 += int'(hi_b[1]);
            m.nlo1 += int'(lo_b[1]);
            m.per++;
            @(negedge clk);
        end while (ps_a !== 1'b1 && m.per < 200);
    endtask

    task automatic wait_hi0(input string name);
        int n;
        n = 0;
        while (hi_a[0] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(hi_a[0]), 32'd1);
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_hi"}, 32'(hi_a), 32'd0);
        check({tag, "_lo"}, 32'(lo_a), 32'd0);
        check({tag, "_hi_nd"}, 32'(hi_b), 32'd0);
        check({tag, "_lo_nd"}, 32'(lo_b), 32'd0);
        check({tag, "_ps"}, 32'(ps_a), 32'd0);
        check({tag, "_cnt"}, 32'(dut.cnt_q), 32'd0);
    endtask

    // ---------------- overlap monitor ----------------
    always @(negedge clk) begin
        checks++;
        ov_a: assert ((hi_a & lo_a) == '0 && (hi_b & lo_b) == '0)
        else begin
            errors++;
            $display("FAIL overlap: hi=%b lo=%b hi_nd=%b lo_nd=%b, required no common bit",
                     hi_a, lo_a, hi_b, lo_b);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        meas_t m;
        vec_t  e;

        //             md    d0     d1     per hi0 lo0 hi1 lo1 nhi0 nhi1
        tbl[0] = '{1'b0, 4'd4,  4'd0,  16,  2, 10,  0, 16,  4,  0};
        tbl[1] = '{1'b0, 4'd2,  4'd15, 16,  0, 12, 13,  0,  2, 15};
        tbl[2] = '{1'b0, 4'd8,  4'd13, 16,  6,  6, 11,  1,  8, 13};
        tbl[3] = '{1'b1, 4'd4,  4'd0,  30,  5, 21,  0, 30,  7,  0};
        tbl[4] = '{1'b1, 4'd10, 4'd15, 30, 17,  9, 27,  0, 19, 29};
        tbl[5] = '{1'b1, 4'd1,  4'd2,  30,  0, 27,  1, 25,  1,  3};
        tbl[6] = '{1'b0, 4'd1,  4'd14, 16,  0, 13, 12,  0,  1, 14};

        // reset state
        repeat (3) @(negedge clk);
        check_all_low("reset");
        check("reset_duty_act0", 32'(dut.duty_act_q[0]), 32'd0);

        rst_n = 1'b1;
        en    = 1'b1;
        drive(tbl[0].md, tbl[0].d0, tbl[0].d1);
        @(negedge clk);
        check("ps_first_en_cycle", 32'(ps_a), 32'd1);

        // table-driven steady-state periods
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].md, tbl[i].d0, tbl[i].d1);
            exp_q.push_back(tbl[i]);
            wait_ps($sformatf("v%0d_load", i));
            wait_ps($sformatf("v%0d_settle", i));
            measure(-1, 0, m);
            e = exp_q.pop_front();
            check($sformatf("v%0d_period", i), 32'(m.per), 32'(e.per));
            check($sformatf("v%0d_hi0", i), 32'(m.hi0), 32'(e.hi0));
            check($sformatf("v%0d_lo0", i), 32'(m.lo0), 32'(e.lo0));
            check($sformatf("v%0d_hi1", i), 32'(m.hi1), 32'(e.hi1));
            check($sformatf("v%0d_lo1", i), 32'(m.lo1), 32'(e.lo1));
            check($sformatf("v%0d_nd_hi0", i), 32'(m.nhi0), 32'(e.nhi0));
            check($sformatf("v%0d_nd_lo0", i), 32'(m.nlo0), 32'(e.per - e.nhi0));
            check($sformatf("v%0d_nd_hi1", i), 32'(m.nhi1), 32'(e.nhi1));
            check($sformatf("v%0d_nd_lo1", i), 32'(m.nlo1), 32'(e.per - e.nhi1));
        end

        // mid-period duty and mode writes wait for the next boundary
        drive(1'b0, 4'd4, 4'd0);
        wait_ps("mid_load");
        wait_ps("mid_settle");
        measure(6, 1, m);
        check("mid_w1_period", 32'(m.per), 32'd16);
        check("mid_w1_raw0", 32'(m.nhi0), 32'd4);
        check("mid_w1_hi0", 32'(m.hi0), 32'd2);
        measure(5, 2, m);
        check("mid_w2_period", 32'(m.per), 32'd16);
        check("mid_w2_raw0", 32'(m.nhi0), 32'd10);
        check("mid_w2_hi0", 32'(m.hi0), 32'd8);
        measure(-1, 0, m);
        check("mid_w3_period", 32'(m.per), 32'd30);
        measure(-1, 0, m);
        check("mid_w4_period", 32'(m.per), 32'd30);
        check("mid_w4_raw0", 32'(m.nhi0), 32'd19);
        check("mid_w4_hi0", 32'(m.hi0), 32'd17);

        // enable drop in the high phase
        wait_hi0("hi0_before_en_drop");
        en = 1'b0;
        @(negedge clk);
        check_all_low("en_drop");
        repeat (3) @(negedge clk);
        check_all_low("en_hold");
        en = 1'b1;
        @(negedge clk);
        check("ps_after_en_rise", 32'(ps_a), 32'd1);
        wait_hi0("hi0_before_reset");

        // asynchronous reset between clock edges
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_low("async_reset");
        check("async_reset_duty_act0", 32'(dut.duty_act_q[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("ps_at_reset_release", 32'(ps_a), 32'd0);
        @(negedge clk);
        check("ps_after_reset_release", 32'(ps_a), 32'd1);

        // random sweep; the overlap monitor checks every cycle
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            en = ($urandom_range(0, 9) != 0);
            repeat ($urandom_range(3, 40)) @(negedge clk);
        end
        en = 1'b1;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
